// File: rtl/vending_controller_param.sv
// vending_controller_param: ROWS x COLS vending controller with a loadable
// price/stock table, coin credit, cancel/refund, sold-out and selection timeout.
`default_nettype none

module vending_controller_param #(
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int AMT_W   = 16,
  parameter int STOCK_W = 4,
  parameter int TIMEOUT = 1000,
  parameter int SEL_W   = $clog2(ROWS*COLS)
) (
  input  logic               I_CLK,
  input  logic               I_RESET,
  input  logic [ROWS-1:0]    I_ROW,
  input  logic [COLS-1:0]    I_COL,
  input  logic               I_COIN_VALID,
  input  logic [AMT_W-1:0]   I_COIN_VAL,
  input  logic               I_CANCEL,
  input  logic               I_CFG_WE,
  input  logic [SEL_W-1:0]   I_CFG_ADDR,
  input  logic [AMT_W-1:0]   I_CFG_PRICE,
  input  logic [STOCK_W-1:0] I_CFG_STOCK,
  output logic [SEL_W-1:0]   O_SEL,
  output logic [AMT_W-1:0]   O_PRICE,
  output logic [AMT_W-1:0]   O_CREDIT,
  output logic [AMT_W-1:0]   O_CHANGE,
  output logic               O_CHANGE_VALID,
  output logic               O_SUCCESS,
  output logic               O_SOLD_OUT,
  output logic               O_COIN_REJECT,
  output logic               O_BUSY
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam int SLOTS = ROWS * COLS;
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ROW_SEL    = 3'd1,
    CHECK      = 3'd2,
    WAIT_FUNDS = 3'd3,
    DISPENSE   = 3'd4,
    CHANGE     = 3'd5
  } state_t;

  state_t             state;
  logic [ROW_W-1:0]   row;
  logic [SEL_W-1:0]   sel;
  logic [TMR_W-1:0]   timer;
  logic [AMT_W-1:0]   price_tbl [SLOTS];
  logic [STOCK_W-1:0] stock_tbl [SLOTS];

  logic [ROW_W-1:0] row_idx;
  logic [COL_W-1:0] col_idx;
  logic             row_press;
  logic             col_press;
  logic [AMT_W:0]   coin_sum;
  logic             coin_ok;
  logic [AMT_W-1:0] credit_upd;
  logic [SEL_W-1:0] sel_new;

  always_comb begin
    row_idx = '0;
    col_idx = '0;
    for (int i = 0; i < ROWS; i++) if (I_ROW[i]) row_idx = ROW_W'(i);
    for (int j = 0; j < COLS; j++) if (I_COL[j]) col_idx = COL_W'(j);
    row_press = |I_ROW;
    col_press = |I_COL;
    // A letter pressed together with the digit is the one that counts.
    sel_new = SEL_W'(int'(row_press ? row_idx : row) * COLS + int'(col_idx));
    coin_sum = {1'b0, O_CREDIT} + {1'b0, I_COIN_VAL};
    coin_ok = I_COIN_VALID && !coin_sum[AMT_W] &&
              (state == IDLE || state == ROW_SEL || state == WAIT_FUNDS);
    credit_upd = coin_ok ? coin_sum[AMT_W-1:0] : O_CREDIT;
  end

  assign O_BUSY = (state != IDLE);

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state          <= IDLE;
      row            <= '0;
      sel            <= '0;
      timer          <= '0;
      O_SEL          <= '0;
      O_PRICE        <= '0;
      O_CREDIT       <= '0;
      O_CHANGE       <= '0;
      O_CHANGE_VALID <= 1'b0;
      O_SUCCESS      <= 1'b0;
      O_SOLD_OUT     <= 1'b0;
      O_COIN_REJECT  <= 1'b0;
      for (int k = 0; k < SLOTS; k++) begin
        price_tbl[k] <= '0;
        stock_tbl[k] <= '0;
      end
    end else begin
      O_CHANGE_VALID <= 1'b0;
      O_SUCCESS      <= 1'b0;
      O_SOLD_OUT     <= 1'b0;
      O_COIN_REJECT  <= I_COIN_VALID && !coin_ok;
      O_CREDIT       <= credit_upd;
      case (state)
        IDLE: begin
          if (I_CFG_WE) begin
            price_tbl[I_CFG_ADDR] <= I_CFG_PRICE;
            stock_tbl[I_CFG_ADDR] <= I_CFG_STOCK;
          end
          if (I_CANCEL && credit_upd != '0) begin
            state <= CHANGE;
          end else if (row_press) begin
            row   <= row_idx;
            timer <= '0;
            state <= ROW_SEL;
          end
        end
        ROW_SEL: begin
          if (I_CANCEL) begin
            state <= CHANGE;
          end else if (col_press) begin
            sel   <= sel_new;
            state <= CHECK;
          end else if (row_press) begin
            row   <= row_idx;
            timer <= '0;
          end else if (timer == TMO_LAST) begin
            state <= IDLE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        CHECK: begin
          O_PRICE <= price_tbl[sel];
          if (stock_tbl[sel] == '0) begin
            O_SOLD_OUT <= 1'b1;
            state      <= IDLE;
          end else if (O_CREDIT >= price_tbl[sel]) begin
            state <= DISPENSE;
          end else begin
            state <= WAIT_FUNDS;
          end
        end
        WAIT_FUNDS: begin
          if (I_CANCEL) begin
            state <= CHANGE;
          end else if (row_press) begin
            row   <= row_idx;
            timer <= '0;
            state <= ROW_SEL;
          end else if (credit_upd >= O_PRICE) begin
            state <= CHECK;
          end
        end
        DISPENSE: begin
          O_SEL            <= sel;
          O_SUCCESS        <= 1'b1;
          stock_tbl[sel]   <= stock_tbl[sel] - STOCK_W'(1);
          O_CREDIT         <= O_CREDIT - O_PRICE;
          state            <= CHANGE;
        end
        CHANGE: begin
          if (O_CREDIT != '0) begin
            O_CHANGE       <= O_CREDIT;
            O_CHANGE_VALID <= 1'b1;
          end
          O_CREDIT <= '0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vending_controller_param.sv
// tb_vending_controller_param: scoreboard bench; expected pulse events are queued
// as stimulus is driven and popped as the controller emits them.
`default_nettype none

module tb_vending_controller_param;

  localparam int ROWS = 4, COLS = 4, AMT_W = 16, STOCK_W = 4, TMO = 20;
  localparam int SEL_W = 4;
  localparam int EV_SUCCESS = 0, EV_CHANGE = 1, EV_SOLD = 2, EV_REJECT = 3;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [ROWS-1:0]    row_in = '0;
  logic [COLS-1:0]    col_in = '0;
  logic               coin_valid = 1'b0;
  logic [AMT_W-1:0]   coin_val = '0;
  logic               cancel = 1'b0;
  logic               cfg_we = 1'b0;
  logic [SEL_W-1:0]   cfg_addr = '0;
  logic [AMT_W-1:0]   cfg_price = '0;
  logic [STOCK_W-1:0] cfg_stock = '0;
  logic [SEL_W-1:0]   sel;
  logic [AMT_W-1:0]   price, credit, change;
  logic               change_valid, success, sold_out, coin_reject, busy;

  int checks = 0;
  int errors = 0;
  int exp_kind[$];
  int exp_val[$];

  vending_controller_param #(
    .ROWS(ROWS), .COLS(COLS), .AMT_W(AMT_W), .STOCK_W(STOCK_W), .TIMEOUT(TMO)
  ) dut (
    .I_CLK(clk), .I_RESET(rst), .I_ROW(row_in), .I_COL(col_in),
    .I_COIN_VALID(coin_valid), .I_COIN_VAL(coin_val), .I_CANCEL(cancel),
    .I_CFG_WE(cfg_we), .I_CFG_ADDR(cfg_addr), .I_CFG_PRICE(cfg_price),
    .I_CFG_STOCK(cfg_stock), .O_SEL(sel), .O_PRICE(price), .O_CREDIT(credit),
    .O_CHANGE(change), .O_CHANGE_VALID(change_valid), .O_SUCCESS(success),
    .O_SOLD_OUT(sold_out), .O_COIN_REJECT(coin_reject), .O_BUSY(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic expect_event(input string tag, input int kind, input logic [31:0] val);
    if (exp_kind.size() == 0) begin
      check({"unexpected_", tag}, 1, 0);
    end else begin
      int k, v;
      k = exp_kind.pop_front();
      v = exp_val.pop_front();
      check({tag, "_kind"}, kind, k);
      check({tag, "_val"}, val, v);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (success)      expect_event("success", EV_SUCCESS, 32'(sel));
      if (change_valid) expect_event("change", EV_CHANGE, 32'(change));
      if (sold_out)     expect_event("sold_out", EV_SOLD, 0);
      if (coin_reject)  expect_event("reject", EV_REJECT, 0);
    end
  end

  task automatic push(input int kind, input int val);
    exp_kind.push_back(kind);
    exp_val.push_back(val);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input int v);
    coin_valid = 1'b1;
    coin_val = AMT_W'(v);
    tick();
    coin_valid = 1'b0;
  endtask

  task automatic press_row(input int r);
    row_in = ROWS'(1 << r);
    tick();
    row_in = '0;
  endtask

  task automatic press_col(input int c);
    col_in = COLS'(1 << c);
    tick();
    col_in = '0;
  endtask

  task automatic do_cancel();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
  endtask

  task automatic cfg(input int addr, input int p, input int s);
    cfg_we = 1'b1;
    cfg_addr = SEL_W'(addr);
    cfg_price = AMT_W'(p);
    cfg_stock = STOCK_W'(s);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      if (!busy) done = 1;
      else tick();
    end
    if (!done) check("idle_timeout", 0, 1);
  endtask

  task automatic buy(input int r, input int c);
    press_row(r);
    press_col(c);
    wait_idle();
  endtask

  initial begin
    tick();
    tick();
    check("rst_credit", credit, 0);
    check("rst_busy", busy, 0);
    check("rst_sel", sel, 0);
    check("rst_price", price, 0);
    check("rst_change", change, 0);
    rst = 1'b0;
    cfg(0, 100, 3);
    cfg(5, 250, 5);
    cfg(15, 200, 5);
    cfg(8, 50, 0);

    // A1 exact payment, latency check, then drain stock to observe decrement
    for (int i = 0; i < 4; i++) coin(25);
    check("a1_credit", credit, 100);
    push(EV_SUCCESS, 0);
    press_row(0);
    press_col(0);
    tick();
    check("lat_cyc1", success, 0);
    tick();
    check("lat_cyc2", success, 1);
    check("a1_sel", sel, 0);
    wait_idle();
    check("a1_credit_after", credit, 0);
    for (int n = 0; n < 2; n++) begin
      coin(100);
      push(EV_SUCCESS, 0);
      buy(0, 0);
    end
    coin(100);
    push(EV_SOLD, 0);
    buy(0, 0);
    check("a1_soldout_credit", credit, 100);
    push(EV_CHANGE, 100);
    do_cancel();
    wait_idle();

    // B2 needs topping up in WAIT_FUNDS
    coin(100);
    coin(100);
    press_row(1);
    press_col(1);
    tick();
    tick();
    check("b2_wait_price", price, 250);
    check("b2_wait_busy", busy, 1);
    push(EV_SUCCESS, 5);
    push(EV_CHANGE, 50);
    coin(100);
    wait_idle();
    check("b2_credit_after", credit, 0);

    // last letter wins: A, B, D then 4
    for (int i = 0; i < 4; i++) coin(100);
    push(EV_SUCCESS, 15);
    push(EV_CHANGE, 200);
    press_row(0);
    press_row(1);
    press_row(3);
    press_col(3);
    wait_idle();
    check("d4_sel", sel, 15);

    // C1 sold out, credit retained, then refund
    coin(100);
    coin(50);
    push(EV_SOLD, 0);
    buy(2, 0);
    check("c1_credit_kept", credit, 150);
    push(EV_CHANGE, 150);
    do_cancel();
    wait_idle();
    check("c1_credit_refunded", credit, 0);

    // overflow rejection and selection timeout
    coin(65530);
    push(EV_REJECT, 0);
    coin(10);
    check("ovf_credit", credit, 65530);
    press_row(0);
    for (int i = 0; i < TMO - 1; i++) tick();
    check("tmo_busy_before", busy, 1);
    tick();
    check("tmo_busy_after", busy, 0);
    check("tmo_credit", credit, 65530);
    push(EV_CHANGE, 65530);
    do_cancel();
    wait_idle();

    // config write outside IDLE is ignored
    coin(100);
    press_row(1);
    press_col(1);
    tick();
    tick();
    cfg(5, 1, 9);
    push(EV_CHANGE, 100);
    do_cancel();
    wait_idle();
    coin(150);
    press_row(1);
    press_col(1);
    tick();
    tick();
    check("cfg_ignored_price", price, 250);
    check("cfg_ignored_busy", busy, 1);

    // reset mid-transaction: everything clears, no refund pulse
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_credit", credit, 0);
    check("rst2_price", price, 0);
    check("rst2_sel", sel, 0);
    check("rst2_change", change, 0);
    check("rst2_busy", busy, 0);
    check("rst2_pulses", {change_valid, success, sold_out, coin_reject}, 0);
    for (int i = 0; i < 4; i++) tick();
    check("queue_empty", exp_kind.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vending_controller_param.md
Name: vending_controller_param

Overview:
- Clocked, parametrised successor to the single-panel vending FSM.
- Supports a ROWS x COLS selection grid, a runtime-loadable price and stock table, and coin-by-coin credit accumulation.
- Adds explicit cancel/refund, sold-out detection, selection timeout and coin rejection.
- Sits between the keypad/coin acceptor front end and the dispense/change-return actuators.

Parameters:
- ROWS, 4, number of letter buttons (A, B, C, D...).
- COLS, 4, number of digit buttons (1, 2, 3, 4...).
- AMT_W, 16, width of all money values in cents.
- STOCK_W, 4, width of the per-slot stock counter.
- TIMEOUT, 1000, number of idle cycles in ROW_SEL before the selection is abandoned.
- SEL_W, $clog2(ROWS*COLS), selection index width (derived).

Ports:
- I_CLK  in  1  clock.
- I_RESET  in  1  synchronous active-high reset.
- I_ROW  in  ROWS  one-hot letter press, 1-cycle pulse.
- I_COL  in  COLS  one-hot digit press, 1-cycle pulse.
- I_COIN_VALID  in  1  coin inserted strobe.
- I_COIN_VAL  in  AMT_W  coin value, qualified by I_COIN_VALID.
- I_CANCEL  in  1  refund request pulse.
- I_CFG_WE  in  1  price/stock table write enable.
- I_CFG_ADDR  in  SEL_W  table slot index.
- I_CFG_PRICE  in  AMT_W  price to write.
- I_CFG_STOCK  in  STOCK_W  stock to write.
- O_SEL  out  SEL_W  dispensed slot, row*COLS+col.
- O_PRICE  out  AMT_W  price of the current selection.
- O_CREDIT  out  AMT_W  accumulated credit.
- O_CHANGE  out  AMT_W  change amount, valid with O_CHANGE_VALID.
- O_CHANGE_VALID  out  1  1-cycle pulse.
- O_SUCCESS  out  1  1-cycle pulse on dispense.
- O_SOLD_OUT  out  1  1-cycle pulse.
- O_COIN_REJECT  out  1  1-cycle pulse.
- O_BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset, synchronous: state=IDLE. All outputs are 0. Credit=0. Price and stock table entries are all 0; the table must be loaded before use.
- Config writes take effect only in IDLE with I_CFG_WE=1. Writes in any other state are ignored.
- Coins, in states IDLE, ROW_SEL and WAIT_FUNDS:
  - credit += I_COIN_VAL on the next edge.
  - If the sum would exceed 2^AMT_W-1, the coin is rejected: credit unchanged, O_COIN_REJECT pulses.
  - In CHECK, DISPENSE and CHANGE every coin is rejected.
- IDLE:
  - Any I_ROW press latches the row and moves to ROW_SEL.
  - I_COL presses are ignored.
  - I_CANCEL with credit>0 moves to CHANGE as a refund.
- ROW_SEL:
  - A new I_ROW press overwrites the row (the last letter wins).
  - An I_COL press latches the column; sel=row*COLS+col; moves to CHECK.
  - After TIMEOUT cycles with no press, returns to IDLE with credit retained.
  - I_CANCEL moves to CHANGE as a full refund.
- CHECK (1 cycle): O_PRICE=price[sel].
  - stock[sel]==0: O_SOLD_OUT pulses, returns to IDLE with credit retained.
  - Otherwise, credit>=price: go to DISPENSE.
  - Otherwise: go to WAIT_FUNDS.
- WAIT_FUNDS:
  - O_PRICE is held.
  - Once credit>=price (evaluated on the updated credit), go to CHECK.
  - I_CANCEL moves to CHANGE as a full refund.
  - A new I_ROW press re-enters ROW_SEL.
- DISPENSE (1 cycle): O_SEL=sel, O_SUCCESS=1, stock[sel] decrements by 1, credit -= price. Go to CHANGE.
- CHANGE (1 cycle):
  - If credit>0: O_CHANGE=credit and O_CHANGE_VALID=1.
  - Credit is cleared; go to IDLE.
  - When credit is 0, no O_CHANGE_VALID pulse is issued.
- Latency from the completing I_COL press to O_SUCCESS is 2 cycles; O_CHANGE_VALID follows 1 cycle later.
- O_SEL and O_PRICE hold their values until next updated. O_CHANGE holds its value. All pulse outputs are 1 cycle wide.
- Simultaneous events:
  - I_CANCEL has priority over I_ROW and I_COL in the same cycle.
  - A coin and a button press in the same cycle are both processed.
- I_RESET mid-transaction discards credit without a refund pulse.

Test Plan:
- Load A1=100/stock 3. Coins 25×4, press A then 1 → O_SUCCESS at +2 cycles, O_SEL=0, no O_CHANGE_VALID, stock[0]=2.
- Load B2=250. Credit 200, press B then 2 → O_PRICE=250 in WAIT_FUNDS. Add coin 100 → O_SUCCESS, O_SEL=5, O_CHANGE=50.
- Load D4=200. Press A, B, D, then 4 with credit 400 → O_SEL=15, O_CHANGE=200, O_SUCCESS=1.
- C1 with stock 0, credit 150, press C then 1 → O_SOLD_OUT pulse, O_CREDIT stays 150. Then I_CANCEL → O_CHANGE=150 with O_CHANGE_VALID.
- Credit 65530, coin 10 → O_COIN_REJECT, credit stays 65530. Press A, then TIMEOUT cycles pass → state IDLE, O_BUSY=0.
- I_CFG_WE asserted while in WAIT_FUNDS → table unchanged. Assert I_RESET in WAIT_FUNDS → next cycle all outputs 0, O_CREDIT=0.
